// File: rtl/regfile_pkg.sv
// Shared defaults, types and constants for the register file with busy scoreboard.
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Per-register busy scoreboard: claims set, writebacks clear, set wins on the same
// address; pending_cnt is registered together with the busy vector.
module regfile_scoreboard_sb
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk_o,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     pending_cnt
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;

  // NOTE: always_comb uses blocking assignments with a default first so no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (clr_en && clr_addr != ADDR_W'(ZERO_REG)) busy_nxt[clr_addr] = 1'b0;
    // Applied after the clear so a new producer supersedes the retiring one.
    if (set_en && set_addr != ADDR_W'(ZERO_REG)) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;

    cnt_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_o or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (x0 hardwired to zero) with NUM_RD combinational read ports and a
// busy scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to readers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk_o,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     reg_wr_E,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          pending_cnt
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_valid;

  assign wr_valid = reg_wr_E && (waddr != ADDR_W'(ZERO_REG));

  // NOTE: the storage array is reset on purpose: every register must read 0 after reset.
  always_ff @(posedge clk_o or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_valid) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_scoreboard_sb #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk_o       (clk_o),
    .rst_n       (rst_n),
    .set_en      (claim_en),
    .set_addr    (claim_addr),
    .clr_en      (reg_wr_E),
    .clr_addr    (waddr),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;

    assign ra      = raddr[i*ADDR_W +: ADDR_W];
    assign ra_zero = (ra == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    // The value being written back this cycle is forwarded, so the reader need not stall.
    assign fwd = wr_valid && (waddr == ra);
    assign rdata[i*DATA_W +: DATA_W] = ra_zero ? '0 : (fwd ? wdata : mem[ra]);
    assign rbusy[i] = busy[ra] && !fwd;
`else
    assign rdata[i*DATA_W +: DATA_W] = ra_zero ? '0 : mem[ra];
    assign rbusy[i] = busy[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic
// compared against a plain array/flag reference model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk_o = 1'b0;
  logic               rst_n;
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata;
  logic [NRD-1:0]     rbusy;
  logic               reg_wr_E;
  reg_addr_t          waddr;
  reg_data_t          wdata;
  logic               claim_en;
  reg_addr_t          claim_addr;
  logic [AW:0]        pending_cnt;

  int errors = 0;
  int checks = 0;

  reg_data_t m_mem  [NR];
  bit        m_busy [NR];

  regfile_scoreboard #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD)
  ) dut (
    .clk_o       (clk_o),
    .rst_n       (rst_n),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .reg_wr_E    (reg_wr_E),
    .waddr       (waddr),
    .wdata       (wdata),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .pending_cnt (pending_cnt)
  );

  always #5 clk_o = ~clk_o;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic bit same_cycle_write(input reg_addr_t a);
    return BYP && rst_n && reg_wr_E && (a != 0) && (waddr == a);
  endfunction

  function automatic reg_data_t exp_data(input reg_addr_t a);
    if (a == 0) return '0;
    if (same_cycle_write(a)) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    return m_busy[a] && !same_cycle_write(a);
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c[AW:0];
  endfunction

  // Present two read addresses and compare every output against the model.
  task automatic probe(input string tag, input reg_addr_t a0, input reg_addr_t a1);
    raddr = {a1, a0};
    #1;
    check($sformatf("%s.rdata0[x%0d]", tag, a0), rdata[DW-1:0],    exp_data(a0));
    check($sformatf("%s.rdata1[x%0d]", tag, a1), rdata[2*DW-1:DW], exp_data(a1));
    check($sformatf("%s.rbusy0[x%0d]", tag, a0), rbusy[0],         exp_busy(a0));
    check($sformatf("%s.rbusy1[x%0d]", tag, a1), rbusy[1],         exp_busy(a1));
    check($sformatf("%s.pending_cnt", tag),      pending_cnt,      exp_cnt());
  endtask

  // Advance one clock; the model commits what the DUT sampled at that edge.
  task automatic tick();
    @(posedge clk_o);
    if (rst_n) begin
      if (reg_wr_E && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reg_wr_E = 1'b0; claim_en = 1'b0;
  endtask

  task automatic drive_write(input reg_addr_t a, input reg_data_t d);
    reg_wr_E = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic drive_claim(input reg_addr_t a);
    claim_en = 1'b1; claim_addr = a;
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; waddr = '0; wdata = '0; claim_addr = '0;
    idle();
    model_reset();

    // Reset state, then every address after release
    tick(); tick();
    probe("in_reset", 5, 31);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) probe("post_reset", reg_addr_t'(i), reg_addr_t'(NR-1-i));

    // Write/read and the dropped write to x0
    drive_write(5, 32'hDEADBEEF);
    probe("wr5_same", 5, 0);
    tick(); idle();
    probe("wr5_next", 5, 5);
    drive_write(0, 32'h0000_1234);
    probe("wr0_same", 0, 5);
    tick(); idle();
    probe("wr0_next", 0, 5);

    // Same-cycle read of a register being written
    drive_write(7, 32'hA5A5A5A5);
    probe("byp7_same", 7, 5);
    check("byp7_direct", rdata[DW-1:0], BYP ? 64'hA5A5A5A5 : 64'h0);
    tick(); idle();
    probe("byp7_next", 7, 0);

    // Claim and clear
    drive_claim(3);
    probe("clm3_same", 3, 0);
    tick(); idle();
    probe("clm3_next", 3, 0);
    check("clm3_cnt", pending_cnt, 1);
    drive_write(3, 32'h3333_0003);
    probe("clr3_same", 3, 3);
    tick(); idle();
    probe("clr3_next", 3, 0);
    check("clr3_cnt", pending_cnt, 0);
    drive_claim(0);
    tick(); idle();
    probe("clm0", 0, 3);

    // Same-address claim + write keeps the register busy
    drive_claim(9);
    tick(); idle();
    probe("x9_busy", 9, 0);
    drive_claim(9); drive_write(9, 32'h9999_9999);
    probe("x9_both_same", 9, 9);
    tick(); idle();
    probe("x9_both_next", 9, 0);
    check("x9_still_busy", rbusy[0], 1'b1);

    // Different-address claim + write: both take effect; re-claim does not double count
    drive_claim(4);
    tick(); idle();
    drive_claim(2); drive_write(4, 32'h4444_4444);
    tick(); idle();
    probe("x2x4", 2, 4);
    drive_claim(2);
    tick(); idle();
    probe("reclaim2", 2, 9);

    // Mid-operation reset with several busy registers and stored data
    drive_claim(10); tick();
    drive_claim(11); drive_write(12, 32'hC0FFEE12); tick(); idle();
    probe("pre_rst", 10, 12);
    drive_claim(13); drive_write(14, 32'h1414_1414);
    rst_n = 1'b0;
    model_reset();
    probe("in_rst", 12, 13);
    tick(); idle();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) probe("after_rst", reg_addr_t'(i), reg_addr_t'(NR-1-i));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reg_addr_t a0, a1;
      reg_wr_E   = ($urandom_range(0, 1) == 1);
      waddr      = reg_addr_t'($urandom_range(0, NR-1));
      wdata      = $urandom;
      claim_en   = ($urandom_range(0, 2) != 0);
      claim_addr = ($urandom_range(0, 3) == 0) ? waddr : reg_addr_t'($urandom_range(0, NR-1));
      a0 = ($urandom_range(0, 2) == 0) ? waddr : reg_addr_t'($urandom_range(0, NR-1));
      a1 = reg_addr_t'($urandom_range(0, NR-1));
      probe("rand", a0, a1);
      tick();
    end
    idle();
    tick();
    probe("final", 1, 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
